// File: rtl/egress_arbiter.sv
// Round-robin egress arbiter: grants one ingress fifo per frame and streams its words out through a 2-entry buffer.
// Define EGRESS_ARBITER_STATS_EN to add the per-port frame_cnt output.
module egress_arbiter #(
  parameter int NPORTS = 4,
  parameter int WIDTH  = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NPORTS-1:0]             fifo_empty,
  output logic [NPORTS-1:0]             fifo_rd_en,
  input  logic [NPORTS*(WIDTH+1)-1:0]   fifo_rd_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [WIDTH-1:0]              out_data,
  output logic                          out_last,
  output logic [$clog2(NPORTS)-1:0]     out_port,
`ifdef EGRESS_ARBITER_STATS_EN
  output logic [NPORTS*16-1:0]          frame_cnt,
`endif
  output logic                          busy
);

  localparam int PW = $clog2(NPORTS);

  typedef enum logic {IDLE, XFER} state_t;

  state_t           state;
  logic [PW-1:0]    rr_ptr;
  logic [PW-1:0]    grant;
  logic [PW-1:0]    grant_next;
  logic [PW-1:0]    sel_port;
  logic             sel_found;
  logic             inflight;
  logic [1:0]       count;
  logic [1:0]       push_slot;
  logic [2:0]       occupancy;
  logic [WIDTH:0]   ret_word;
  logic             pending_last;
  logic             accept;
  logic             pop;

  logic [WIDTH-1:0] buf_data [2];
  logic             buf_last [2];
  logic [PW-1:0]    buf_port [2];

  assign ret_word     = fifo_rd_data[grant*(WIDTH+1) +: (WIDTH+1)];
  assign pending_last = inflight & ret_word[WIDTH];
  assign accept       = out_valid & out_ready;
  assign occupancy    = {1'b0, count} + {2'b00, inflight};
  assign grant_next   = (grant == PW'(NPORTS-1)) ? '0 : grant + 1'b1;
  assign push_slot    = count - {1'b0, accept};

  // A pop is only issued when the word it returns is guaranteed a buffer slot.
  assign pop = (state == XFER) && !fifo_empty[grant] && !pending_last &&
               (occupancy < (3'd2 + {2'b00, accept}));

  assign out_valid = (count != 2'd0);
  assign out_data  = buf_data[0];
  assign out_last  = buf_last[0];
  assign out_port  = buf_port[0];
  assign busy      = (state == XFER);

  always_comb begin
    fifo_rd_en = '0;
    if (pop && !rst) fifo_rd_en[grant] = 1'b1;
  end

  // First non-empty port at or after rr_ptr, wrapping.
  always_comb begin
    int idx;
    idx       = 0;
    sel_found = 1'b0;
    sel_port  = '0;
    for (int k = 0; k < NPORTS; k++) begin
      idx = (int'(rr_ptr) + k) % NPORTS;
      if (!sel_found && !fifo_empty[idx]) begin
        sel_found = 1'b1;
        sel_port  = PW'(idx);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      grant    <= '0;
      inflight <= 1'b0;
    end else begin
      inflight <= pop;
      case (state)
        IDLE: begin
          if (sel_found) begin
            grant <= sel_port;
            state <= XFER;
          end
        end
        XFER: begin
          if (pending_last) begin
            rr_ptr <= grant_next;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Entry 0 is always the oldest; a returning word lands just behind whatever survives this cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        buf_data[i] <= '0;
        buf_last[i] <= 1'b0;
        buf_port[i] <= '0;
      end
    end else begin
      count <= count + {1'b0, inflight} - {1'b0, accept};
      if (accept) begin
        buf_data[0] <= buf_data[1];
        buf_last[0] <= buf_last[1];
        buf_port[0] <= buf_port[1];
      end
      if (inflight) begin
        if (push_slot == 2'd0) begin
          buf_data[0] <= ret_word[WIDTH-1:0];
          buf_last[0] <= ret_word[WIDTH];
          buf_port[0] <= grant;
        end else begin
          buf_data[1] <= ret_word[WIDTH-1:0];
          buf_last[1] <= ret_word[WIDTH];
          buf_port[1] <= grant;
        end
      end
    end
  end

`ifdef EGRESS_ARBITER_STATS_EN
  logic [15:0] frame_ctr [NPORTS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NPORTS; i++) frame_ctr[i] <= 16'd0;
    end else if (accept && out_last) begin
      frame_ctr[out_port] <= frame_ctr[out_port] + 16'd1;
    end
  end

  for (genvar g = 0; g < NPORTS; g++) begin : g_frame_cnt
    assign frame_cnt[g*16 +: 16] = frame_ctr[g];
  end
`endif

endmodule
